// File: rtl/regfile_write_master_if.sv
// Bundles the CPU writeback request, the I/O valid/ready producer and the
// register-file write port that regfile_write_master owns.
interface regfile_write_master_if;
    // CPU writeback source
    logic        cpu_we;
    logic [4:0]  cpu_wr_reg;
    logic [31:0] cpu_wr_data;
    logic        cpu_stall;
    // I/O producer handshake
    logic        io_valid;
    logic        io_ready;
    logic [4:0]  io_reg;
    logic [31:0] io_data;
    // register file write port
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    // Arbiter side: consumes both sources, drives the write port.
    modport master (
        input  cpu_we, cpu_wr_reg, cpu_wr_data,
        input  io_valid, io_reg, io_data,
        output cpu_stall, io_ready,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );

    // Environment side: CPU, I/O producer and register file.
    modport slave (
        output cpu_we, cpu_wr_reg, cpu_wr_data,
        output io_valid, io_reg, io_data,
        input  cpu_stall, io_ready,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/regfile_write_master.sv
// Single owner of the register-file write port. CPU writeback has priority;
// I/O writes queue in a small FIFO and get a forced slot after STARVE_LIMIT
// cycles of losing to the CPU. Writes to r0 are consumed but never issued.
module regfile_write_master #(
    parameter int IO_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                           clock,
    input  logic                           ctrl_reset,
    regfile_write_master_if.master         bus,
    output logic [$clog2(IO_FIFO_DEPTH):0] io_fifo_count,
    output logic [7:0]                     r0_drop_count,
    output logic                           proto_err
);
    localparam int          AW         = $clog2(IO_FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(IO_FIFO_DEPTH);
    localparam logic [7:0]  LIMIT      = 8'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_entry_t;

    wr_entry_t     fifo_mem [IO_FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [7:0]    starve_cnt;

    logic      empty;
    logic      full;
    logic      stall;
    logic      push;
    logic      sel_io;
    logic      sel_cpu;
    logic      drop;
    wr_entry_t sel;

    assign empty         = (count == '0);
    assign full          = (count == FULL_COUNT);
    // Pure register decode so the CPU sees no combinational path from its own request.
    assign stall         = (starve_cnt == LIMIT);
    assign bus.cpu_stall = stall;
    assign bus.io_ready  = !full && !ctrl_reset;
    assign io_fifo_count = count;
    assign push          = bus.io_valid && bus.io_ready;

    // A forced slot beats the CPU; otherwise the CPU wins and I/O fills idle cycles.
    assign sel_io  = !empty && (stall || !bus.cpu_we);
    assign sel_cpu = bus.cpu_we && !sel_io;
    assign drop    = (sel_io || sel_cpu) && (sel.rd == 5'd0);

    // Pick the entry that owns the write port next cycle.
    always_comb begin
        sel = '{rd: bus.cpu_wr_reg, data: bus.cpu_wr_data};
        if (sel_io)
            sel = fifo_mem[rd_ptr];
    end

    // I/O FIFO: circular buffer, pop whenever the arbiter takes the head.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < IO_FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{rd: bus.io_reg, data: bus.io_data};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (sel_io)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, sel_io})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Starvation counter: cycles the current I/O head has lost to the CPU.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            starve_cnt <= '0;
        else if (empty || sel_io)
            starve_cnt <= '0;
        else if (sel_cpu)
            starve_cnt <= starve_cnt + 8'd1;
    end

    // Write port register; address/data hold whenever the enable is low.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            bus.ctrl_writeEnable <= 1'b0;
            bus.ctrl_writeReg    <= '0;
            bus.data_writeReg    <= '0;
        end else begin
            bus.ctrl_writeEnable <= (sel_io || sel_cpu) && !drop;
            if ((sel_io || sel_cpu) && !drop) begin
                bus.ctrl_writeReg <= sel.rd;
                bus.data_writeReg <= sel.data;
            end
        end
    end

    // Saturating count of consumed r0 writes from either source.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            r0_drop_count <= '0;
        else if (drop && r0_drop_count != 8'hFF)
            r0_drop_count <= r0_drop_count + 8'd1;
    end

    // Sticky flag: the CPU issued a write during a forced I/O slot.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)
            proto_err <= 1'b0;
        else if (bus.cpu_we && stall)
            proto_err <= 1'b1;
    end
endmodule

// File: tb/tb_regfile_write_master.sv
// Directed bench for regfile_write_master with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_regfile_write_master;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic                      clock;
    logic                      ctrl_reset;
    logic [$clog2(DEPTH):0]    io_fifo_count;
    logic [7:0]                r0_drop_count;
    logic                      proto_err;

    regfile_write_master_if bus ();

    regfile_write_master #(.IO_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .bus           (bus),
        .io_fifo_count (io_fifo_count),
        .r0_drop_count (r0_drop_count),
        .proto_err     (proto_err)
    );

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model ----------------
    ent_t        q[$];
    int          m_wait;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    int          m_drops;
    logic        m_perr;

    initial begin : model
        ent_t e;
        bit   have;
        bit   push_now;
        bit   forced;
        bit   busy;
        m_wait = 0; m_we = 0; m_reg = 0; m_data = 0; m_drops = 0; m_perr = 0;
        forever begin
            @(posedge clock);
            if (ctrl_reset) begin
                q.delete();
                m_wait = 0; m_we = 0; m_reg = 0; m_data = 0; m_drops = 0; m_perr = 0;
            end else begin
                push_now = bus.io_valid && (q.size() < DEPTH);
                forced   = (m_wait == LIMIT);
                busy     = (q.size() != 0);
                have     = 1;
                e        = '0;
                if (bus.cpu_we && forced) m_perr = 1;
                if (busy && (forced || !bus.cpu_we)) begin
                    e = q.pop_front();
                    m_wait = 0;
                end else if (bus.cpu_we) begin
                    e = '{rd: bus.cpu_wr_reg, data: bus.cpu_wr_data};
                    if (busy) m_wait++;
                end else begin
                    have = 0;
                end
                if (!busy) m_wait = 0;
                if (!have) m_we = 0;
                else if (e.rd == 5'd0) begin
                    m_we = 0;
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_we = 1; m_reg = e.rd; m_data = e.data;
                end
                if (push_now) q.push_back('{rd: bus.io_reg, data: bus.io_data});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic        e_we, e_rdy, e_stall, e_perr;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        int          e_cnt, e_drops;
        forever begin
            @(negedge clock);
            if (ctrl_reset) begin
                e_we = 0; e_reg = 0; e_data = 0; e_rdy = 0; e_stall = 0;
                e_cnt = 0; e_drops = 0; e_perr = 0;
            end else begin
                e_we = m_we; e_reg = m_reg; e_data = m_data;
                e_rdy = (q.size() < DEPTH);
                e_stall = (m_wait == LIMIT);
                e_cnt = q.size(); e_drops = m_drops; e_perr = m_perr;
            end
            chk("m_we",    32'(bus.ctrl_writeEnable), 32'(e_we));
            chk("m_reg",   32'(bus.ctrl_writeReg),    32'(e_reg));
            chk("m_data",  bus.data_writeReg,         e_data);
            chk("m_ready", 32'(bus.io_ready),         32'(e_rdy));
            chk("m_stall", 32'(bus.cpu_stall),        32'(e_stall));
            chk("m_count", 32'(io_fifo_count),        32'(e_cnt));
            chk("m_drops", 32'(r0_drop_count),        32'(e_drops));
            chk("m_perr",  32'(proto_err),            32'(e_perr));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int   k;
        int   pushed;
        int   cyc;
        bit   acc;
        bit   ready_after4;
        logic [31:0] cnt_after4;
        ctrl_reset = 1'b1;
        bus.cpu_we = 0; bus.cpu_wr_reg = 0; bus.cpu_wr_data = 0;
        bus.io_valid = 0; bus.io_reg = 0; bus.io_data = 0;
        step(); step();
        chk("rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
        chk("rst_ready", 32'(bus.io_ready),         32'd0);
        chk("rst_count", 32'(io_fifo_count),        32'd0);
        ctrl_reset = 1'b0;
        step();
        chk("ready_idle", 32'(bus.io_ready), 32'd1);

        // CPU latency: visible on the port for exactly one cycle, then holds address/data
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd5; bus.cpu_wr_data = 32'hDEADBEEF;
        step();
        bus.cpu_we = 0;
        chk("cpu_we",   32'(bus.ctrl_writeEnable), 32'd1);
        chk("cpu_reg",  32'(bus.ctrl_writeReg),    32'd5);
        chk("cpu_data", bus.data_writeReg,         32'hDEADBEEF);
        step();
        chk("cpu_we_off",   32'(bus.ctrl_writeEnable), 32'd0);
        chk("cpu_reg_hold", 32'(bus.ctrl_writeReg),    32'd5);

        // Starvation guard: stall appears 8 cycles after the entry is eligible
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd10; bus.cpu_wr_data = 32'd1;
        bus.io_valid = 1; bus.io_reg = 5'd7; bus.io_data = 32'h7777;
        step();
        bus.io_valid = 0;
        k = 0;
        while (!bus.cpu_stall && k < 20) begin
            bus.cpu_wr_data = bus.cpu_wr_data + 1;
            step();
            k++;
        end
        chk("stall_delay", 32'(k), 32'd8);
        bus.cpu_we = 0;
        step();
        chk("starve_we",    32'(bus.ctrl_writeEnable), 32'd1);
        chk("starve_reg",   32'(bus.ctrl_writeReg),    32'd7);
        chk("starve_data",  bus.data_writeReg,         32'h7777);
        chk("starve_clear", 32'(bus.cpu_stall),        32'd0);
        step();

        // Fill and handshake: CPU writes every cycle it may, five I/O pushes
        pushed = 0; cyc = 0; ready_after4 = 1; cnt_after4 = 0;
        bus.io_valid = 1; bus.io_reg = 5'd1; bus.io_data = 32'h101;
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd16;
        while (pushed < 5 && cyc < 200) begin
            acc = bus.io_valid && bus.io_ready;
            step();
            cyc++;
            if (acc) begin
                pushed++;
                if (pushed == 4) begin
                    ready_after4 = bus.io_ready;
                    cnt_after4 = 32'(io_fifo_count);
                end
                if (pushed < 5) begin
                    bus.io_reg = 5'(pushed + 1);
                    bus.io_data = 32'h101 + 32'(pushed);
                end else begin
                    bus.io_valid = 0;
                end
            end
            bus.cpu_we = !bus.cpu_stall;
            bus.cpu_wr_reg = 5'(16 + (cyc % 8));
            bus.cpu_wr_data = 32'(cyc);
        end
        chk("ready_full", 32'(ready_after4), 32'd0);
        chk("count_full", cnt_after4,        32'd4);
        chk("pushed_all", 32'(pushed),       32'd5);
        bus.cpu_we = 0;
        k = 0;
        while (io_fifo_count != 0 && k < 20) begin step(); k++; end
        chk("drained", 32'(io_fifo_count), 32'd0);
        step();

        // r0 filter from both sources
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd0; bus.cpu_wr_data = 32'h1234;
        step();
        bus.cpu_we = 0;
        chk("r0_cpu_we",   32'(bus.ctrl_writeEnable), 32'd0);
        chk("r0_cpu_cnt",  32'(r0_drop_count),        32'd1);
        bus.io_valid = 1; bus.io_reg = 5'd0; bus.io_data = 32'h55;
        step();
        bus.io_valid = 0;
        step();
        chk("r0_io_we",    32'(bus.ctrl_writeEnable), 32'd0);
        chk("r0_io_pop",   32'(io_fifo_count),        32'd0);
        chk("r0_io_cnt",   32'(r0_drop_count),        32'd2);
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd0;
        for (int i = 0; i < 300; i++) step();
        bus.cpu_we = 0;
        chk("r0_sat",      32'(r0_drop_count),        32'd255);
        step();

        // Protocol error: CPU ignores the stall
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd9; bus.cpu_wr_data = 32'h9;
        bus.io_valid = 1; bus.io_reg = 5'd12; bus.io_data = 32'h1212;
        step();
        bus.io_valid = 0;
        k = 0;
        while (!bus.cpu_stall && k < 20) begin step(); k++; end
        chk("perr_stall", 32'(bus.cpu_stall), 32'd1);
        bus.cpu_wr_data = 32'hBAD;
        step();
        bus.cpu_we = 0;
        chk("perr_reg",  32'(bus.ctrl_writeReg), 32'd12);
        chk("perr_data", bus.data_writeReg,      32'h1212);
        chk("perr_set",  32'(proto_err),         32'd1);
        for (int i = 0; i < 100; i++) step();
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // Reset mid-stream with three queued entries
        bus.cpu_we = 1; bus.cpu_wr_reg = 5'd3; bus.cpu_wr_data = 32'h3;
        bus.io_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.io_reg = 5'(20 + i); bus.io_data = 32'hA0 + 32'(i);
            step();
        end
        bus.io_valid = 0;
        chk("pre_rst_count", 32'(io_fifo_count), 32'd3);
        ctrl_reset = 1'b1;
        bus.cpu_we = 0;
        #1;
        chk("mid_rst_we",    32'(bus.ctrl_writeEnable), 32'd0);
        chk("mid_rst_reg",   32'(bus.ctrl_writeReg),    32'd0);
        chk("mid_rst_data",  bus.data_writeReg,         32'd0);
        chk("mid_rst_count", 32'(io_fifo_count),        32'd0);
        chk("mid_rst_drops", 32'(r0_drop_count),        32'd0);
        chk("mid_rst_perr",  32'(proto_err),            32'd0);
        chk("mid_rst_ready", 32'(bus.io_ready),         32'd0);
        step(); step();
        ctrl_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_we", 32'(bus.ctrl_writeEnable), 32'd0);
        end
        chk("post_rst_count", 32'(io_fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_master.md
# regfile_write_master

Single-owner driver for the register file write port (`ctrl_writeEnable`, `ctrl_writeReg`, `data_writeReg`). It merges two write sources:

- the CPU writeback stage, which has priority;
- an I/O producer such as the paddle/button sampler, buffered through a small FIFO behind a valid/ready handshake.

It adds a starvation guard so I/O writes are never blocked indefinitely, and it filters writes to r0 before they reach the port.

## Interface
- `IO_FIFO_DEPTH`, 4: I/O FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 8: cycles an I/O head may wait before a forced slot; 1..255.
- `clock` in 1: system clock, rising edge.
- `ctrl_reset` in 1: reset. Asynchronous, active-high.
- `cpu_we` in 1: CPU writeback request for this cycle. No handshake; the CPU must not assert it while `cpu_stall`=1.
- `cpu_wr_reg` in 5: CPU destination register.
- `cpu_wr_data` in 32: CPU write data.
- `io_valid` in 1: I/O write request valid.
- `io_ready` out 1: FIFO can accept. Equals `!full && !ctrl_reset`.
- `io_reg` in 5: I/O destination register.
- `io_data` in 32: I/O write data.
- `cpu_stall` out 1: the current cycle is a forced I/O slot.
- `ctrl_writeEnable` out 1: registered write enable to the register file.
- `ctrl_writeReg` out 5: registered write address.
- `data_writeReg` out 32: registered write data.
- `io_fifo_count` out log2(`IO_FIFO_DEPTH`)+1: FIFO occupancy.
- `r0_drop_count` out 8: saturating count of suppressed r0 writes, both sources.
- `proto_err` out 1: sticky; set when `cpu_we`=1 during `cpu_stall`=1.

## Operation
**FIFO**
- Circular buffer with wrapping read and write pointers.
- Push on `io_valid && io_ready`.
- Pop when the arbiter selects the I/O head.
- Push and pop in the same edge leave the count unchanged.
- No push while full, because `io_ready`=0.

**Arbitration**, evaluated every rising edge, first match wins:
1. `cpu_stall`=1 and FIFO non-empty: select the I/O head and pop it.
   - If `cpu_we`=1 in the same cycle, the CPU write is discarded and `proto_err` is set.
2. `cpu_we`=1: select the CPU write.
3. FIFO non-empty: select the I/O head and pop it.
4. Otherwise: idle, and `ctrl_writeEnable`=0 next cycle.

**r0 filter**
- If the selected address is 0, the entry is consumed: the I/O entry is popped, or the CPU write is retired.
- `ctrl_writeEnable` is 0 for that slot.
- `r0_drop_count` increments and saturates at 255.

**Starvation counter** (`starve_cnt`, 8 bits)
- Cleared when the FIFO is empty or the I/O head is selected.
- Otherwise increments while FIFO non-empty and the CPU wins.
- `cpu_stall` = (`starve_cnt` == `STARVE_LIMIT`). It decodes a register only, with no combinational input path.

**Outputs and ordering**
- `ctrl_writeReg` and `data_writeReg` hold their last value when `ctrl_writeEnable`=0.
- I/O writes commit in FIFO order.
- CPU writes commit in issue order.
- No ordering is guaranteed between the two sources.

**Reset**
- All FIFO contents and pointers, `starve_cnt`, and every output register go to 0.
- Therefore `ctrl_writeEnable`=0, `ctrl_writeReg`=0, `data_writeReg`=0, `cpu_stall`=0, `io_fifo_count`=0, `r0_drop_count`=0, `proto_err`=0, `io_ready`=0.
- Reset mid-operation discards all queued I/O entries and any write in flight. No partial write reaches the register file after reset deasserts.

## Timing
- A CPU write sampled at edge N appears on the write port during cycle N+1 and is committed by the register file at edge N+2.
- An I/O write pushed at edge N is eligible at edge N+1 and is committed at edge N+3 at the earliest.
- Sustained throughput is one write per cycle.
- With the CPU writing every cycle and the FIFO non-empty, one I/O write retires every `STARVE_LIMIT`+1 cycles.
- `io_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- `proto_err` asserts the cycle after the violation and stays high until reset.

## Test plan
- **Reset defaults:** assert `ctrl_reset` mid-stream with the FIFO holding 3 entries. All outputs are 0, `io_fifo_count`=0, and after release no write of the queued data appears.
- **CPU latency:** `cpu_we`=1, reg 5, data 0xDEADBEEF at edge N. The port shows writeEnable=1, reg 5, 0xDEADBEEF during cycle N+1 only.
- **Fill and handshake:** CPU writes every cycle; push 5 I/O writes (regs 1–5) with `IO_FIFO_DEPTH`=4. `io_ready` drops after 4 pushes, and the 5th is held until space frees.
- **Starvation guard:** `STARVE_LIMIT`=8, continuous `cpu_we`, one I/O write to reg 7.
  - `cpu_stall` asserts exactly 8 cycles after the entry becomes eligible.
  - reg 7 is written the next cycle, and `starve_cnt` restarts.
- **Protocol error:** `cpu_we`=1 during `cpu_stall`. The CPU write never reaches the port, `proto_err`=1, and it is still 1 after 100 idle cycles.
- **r0 filter:**
  - CPU and I/O writes to reg 0: `ctrl_writeEnable` stays 0, the FIFO pops, and `r0_drop_count` increments by 2.
  - 300 r0 writes: the counter saturates at 255.
